// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters; grant held until ACCESS/ERROR/timeout.
// Latency: request seen in IDLE cycle t drives the RAM from t+1; minimum 2 cycles per access.
// Backpressure: req_wait_o stays high except on the completion cycle; optional MEM_ARB_PERF_EN adds grant_cnt_o.
module memory_arbiter_rr #(
  parameter int NREQ    = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_ren_i,
  input  logic [NREQ-1:0]      req_wen_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_store_i,
  output logic [NREQ-1:0]      req_wait_o,
  output logic [DW-1:0]        req_load_o,
  output logic [NREQ-1:0]      req_err_o,
  output logic                 ram_ren_o,
  output logic                 ram_wen_o,
  output logic [AW-1:0]        ram_addr_o,
  output logic [DW-1:0]        ram_store_o,
  input  logic [DW-1:0]        ram_load_i,
  input  logic [1:0]           ram_state_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt_o
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [NREQ-1:0] act;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic            in_act, act_g, acc, rerr, to_hit, done_ok, done_to;
  logic [IW-1:0]   next_ptr;

  assign act      = req_ren_i | req_wen_i;
  assign in_act   = (state_q == ACTIVE);
  assign act_g    = act[grant_q];
  assign acc      = (ram_state_i == 2'b10);
  assign rerr     = (ram_state_i == 2'b11);
  assign to_hit   = TO_EN && (timer_q == TLAST);
  // A dropped request (abort) takes precedence: the requester is no longer waiting for a result.
  assign done_ok  = in_act & act_g & (acc | rerr);
  assign done_to  = in_act & act_g & ~acc & ~rerr & to_hit;
  assign next_ptr = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  // Round-robin pick: first active requester at or after ptr, wrapping upward.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (act[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  // State and arbitration registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant in ACTIVE until completion or abort.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          timer_d = '0;
          state_d = ACTIVE;
        end
      end
      default: begin
        if (!act_g) begin
          state_d = IDLE;
        end else if (done_ok || done_to) begin
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else begin
          timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs: RAM is driven only from the granted requester while ACTIVE; write masks read.
  always_comb begin
    req_wait_o  = '1;
    req_err_o   = '0;
    req_load_o  = '0;
    ram_ren_o   = 1'b0;
    ram_wen_o   = 1'b0;
    ram_addr_o  = '0;
    ram_store_o = '0;
    if (in_act) begin
      ram_addr_o  = req_addr_i[grant_q*AW +: AW];
      ram_store_o = req_store_i[grant_q*DW +: DW];
      ram_wen_o   = req_wen_i[grant_q];
      ram_ren_o   = req_ren_i[grant_q] & ~req_wen_i[grant_q];
      if (done_ok || done_to) req_wait_o[grant_q] = 1'b0;
      if (done_ok) req_load_o = ram_load_i;
      if ((done_ok && rerr) || done_to) req_err_o[grant_q] = 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [NREQ-1:0][15:0] cnt_q;
  logic                  ok_cmpl;

  assign ok_cmpl     = done_ok & acc;
  assign grant_cnt_o = cnt_q;

  // Per-requester saturating count of successful completions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (ok_cmpl) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_q == IW'(i) && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Self-checking bench for memory_arbiter_rr: directed scenarios plus randomized traffic.
// Expected values come from a cycle-level behavioural model of the arbitration rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_memory_arbiter_rr;
  localparam int NREQ = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      ren, wen;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   store;
  logic [NREQ-1:0]      req_wait, req_err;
  logic [DW-1:0]        req_load;
  logic                 ram_ren, ram_wen;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_store;
  logic [DW-1:0]        ram_load;
  logic [1:0]           ram_state;
`ifdef MEM_ARB_PERF_EN
  logic [NREQ*16-1:0]   grant_cnt;
`endif

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  bit m_busy; int m_g, m_ptr, m_timer; int m_cnt[NREQ];
  bit n_busy; int n_g, n_ptr, n_timer; bit e_inc;
  logic [NREQ-1:0] e_wait, e_err;
  logic [DW-1:0] e_load, e_store;
  logic [AW-1:0] e_addr;
  logic e_ren, e_wen;

  always #5 clk = ~clk;

  memory_arbiter_rr #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_ren_i(ren), .req_wen_i(wen), .req_addr_i(addr), .req_store_i(store),
    .req_wait_o(req_wait), .req_load_o(req_load), .req_err_o(req_err),
    .ram_ren_o(ram_ren), .ram_wen_o(ram_wen), .ram_addr_o(ram_addr), .ram_store_o(ram_store),
    .ram_load_i(ram_load), .ram_state_i(ram_state)
`ifdef MEM_ARB_PERF_EN
    , .grant_cnt_o(grant_cnt)
`endif
  );

  function automatic void model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_timer = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endfunction

  // Expected outputs for the current cycle and the state after the next edge.
  function automatic void model_eval();
    int g;
    e_wait = '1; e_err = '0; e_load = '0; e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_inc = 0;
    n_busy = m_busy; n_g = m_g; n_ptr = m_ptr; n_timer = m_timer;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (ren[j] || wen[j]) begin
          n_busy = 1; n_g = j; n_timer = 0;
          break;
        end
      end
    end else begin
      g = m_g;
      e_addr = addr[g*AW +: AW];
      e_store = store[g*DW +: DW];
      if (!(ren[g] || wen[g])) begin
        n_busy = 0;
      end else begin
        e_wen = wen[g];
        e_ren = ren[g] & ~wen[g];
        if (ram_state == 2'b10 || ram_state == 2'b11) begin
          e_wait[g] = 0; e_load = ram_load; e_err[g] = (ram_state == 2'b11);
          e_inc = (ram_state == 2'b10); n_busy = 0; n_ptr = (g + 1) % NREQ;
        end else if (m_timer == TIMEOUT - 1) begin
          e_wait[g] = 0; e_err[g] = 1; n_busy = 0; n_ptr = (g + 1) % NREQ;
        end else begin
          n_timer = m_timer + 1;
        end
      end
    end
  endfunction

  function automatic void model_commit();
    if (e_inc && m_cnt[m_g] < 65535) m_cnt[m_g]++;
    m_busy = n_busy; m_g = n_g; m_ptr = n_ptr; m_timer = n_timer;
  endfunction

  task automatic tick();
    @(negedge clk);
    model_eval();
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) model_reset(); else model_commit();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1; ren = '0; wen = '0; addr = '0; store = '0; ram_state = 2'b00; ram_load = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1;
    @(negedge clk);
    checks++; if (req_wait !== 3'b111) $display("FAIL reset_wait: got %b expected 111", req_wait); else passed++;
    checks++;
    if ({ram_ren, ram_wen, req_err, req_load, ram_addr, ram_store} !== '0)
      $display("FAIL reset_outputs: got ren=%b wen=%b err=%b load=%h addr=%h store=%h expected all zero",
               ram_ren, ram_wen, req_err, req_load, ram_addr, ram_store);
    else passed++;
    @(posedge clk); #1; rst = 0;
    addr = {32'h300, 32'h200, 32'h100}; ren = 3'b001; ram_state = 2'b10;
    tick(); adv();
    tick();
    checks++; if (req_wait !== 3'b110) $display("FAIL reset_pre_cmpl: got %b expected 110", req_wait); else passed++;
    adv();
    ren = 3'b010; ram_state = 2'b01;
    tick(); adv();
    tick();
    checks++; if (ram_ren !== 1'b1 || ram_addr !== 32'h200)
      $display("FAIL reset_pre_active: got ren=%b addr=%h expected 1/00000200", ram_ren, ram_addr); else passed++;
    rst = 1; #1;
    checks++; if (req_wait !== 3'b111 || ram_ren !== 1'b0 || ram_wen !== 1'b0)
      $display("FAIL reset_mid_active: got wait=%b ren=%b wen=%b expected 111/0/0", req_wait, ram_ren, ram_wen);
    else passed++;
    model_reset();
    @(posedge clk); #1; rst = 0; ren = 3'b111;
    tick(); adv();
    tick();
    checks++; if (ram_addr !== 32'h100)
      $display("FAIL reset_ptr_zero: got addr=%h expected 00000100", ram_addr); else passed++;
    adv();
  endtask

  task automatic test_single_read();
    int drops, dcyc;
    logic [31:0] dload;
    apply_reset();
    addr[63:32] = 32'h40; ren = 3'b010;
    drops = 0; dcyc = -1; dload = '0;
    for (int c = 0; c < 8; c++) begin
      ram_state = (c == 4) ? 2'b10 : 2'b01;
      ram_load = (c == 4) ? 32'hDEADBEEF : 32'h0BADF00D;
      tick();
      checks++; if (req_wait !== e_wait) $display("FAIL read_wait c%0d: got %b expected %b", c, req_wait, e_wait); else passed++;
      if (c >= 1 && c <= 4) begin
        checks++; if (ram_ren !== 1'b1 || ram_addr !== 32'h40)
          $display("FAIL read_drive c%0d: got ren=%b addr=%h expected 1/00000040", c, ram_ren, ram_addr); else passed++;
      end
      if (req_wait[1] === 1'b0) begin drops++; dcyc = c; dload = req_load; end
      adv();
      if (c == 4) ren = '0;
    end
    checks++; if (drops != 1) $display("FAIL read_drop_count: got %0d expected 1", drops); else passed++;
    checks++; if (dcyc != 4) $display("FAIL read_drop_cycle: got %0d expected 4", dcyc); else passed++;
    checks++; if (dload !== 32'hDEADBEEF) $display("FAIL read_load: got %h expected deadbeef", dload); else passed++;
  endtask

  task automatic test_fairness();
    int ord[$];
    int cyc[$];
    apply_reset();
    addr = {32'h300, 32'h200, 32'h100}; ren = 3'b111; ram_state = 2'b10; ram_load = 32'h5555;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if (req_wait !== e_wait) $display("FAIL fair_wait c%0d: got %b expected %b", c, req_wait, e_wait); else passed++;
      if (req_wait !== 3'b111) begin
        for (int i = 0; i < NREQ; i++) if (req_wait[i] === 1'b0) ord.push_back(i);
        cyc.push_back(c);
      end
      adv();
    end
    ren = '0;
    checks++; if (ord.size() != 6) $display("FAIL fair_count: got %0d expected 6", ord.size()); else passed++;
    for (int k = 0; k < ord.size(); k++) begin
      checks++; if (ord[k] != k % 3) $display("FAIL fair_order %0d: got %0d expected %0d", k, ord[k], k % 3); else passed++;
      if (k >= 1 && k < cyc.size()) begin
        checks++; if (cyc[k] - cyc[k-1] != 2)
          $display("FAIL fair_spacing %0d: got %0d expected 2", k, cyc[k] - cyc[k-1]); else passed++;
      end
    end
  endtask

  task automatic test_write_priority();
    apply_reset();
    ren = 3'b001; wen = 3'b001; store[31:0] = 32'h1234; addr[31:0] = 32'h80; ram_state = 2'b01;
    tick();
    checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0)
      $display("FAIL wr_idle_enables: got ren=%b wen=%b expected 0/0", ram_ren, ram_wen); else passed++;
    adv();
    tick();
    checks++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_store !== 32'h1234)
      $display("FAIL wr_priority: got wen=%b ren=%b store=%h expected 1/0/00001234", ram_wen, ram_ren, ram_store);
    else passed++;
    adv();
    ram_state = 2'b10;
    tick();
    checks++; if (req_wait !== 3'b110 || req_err !== 3'b000)
      $display("FAIL wr_complete: got wait=%b err=%b expected 110/000", req_wait, req_err); else passed++;
    adv();
    ren = '0; wen = '0;
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      int dcyc;
      logic derr;
      logic [31:0] dload, xload;
      apply_reset();
      ren = 3'b100; addr[95:64] = 32'h7000;
      dcyc = -1; derr = 1'bx; dload = 'x;
      xload = (pass == 1) ? 32'hA5A50008 : 32'h0;
      for (int c = 0; c < 12; c++) begin
        ram_state = (pass == 1 && c == 8) ? 2'b10 : 2'b01;
        ram_load = 32'hA5A50000 | c;
        tick();
        checks++; if (req_wait !== e_wait || req_err !== e_err)
          $display("FAIL to_cycle p%0d c%0d: got wait=%b err=%b expected %b/%b", pass, c, req_wait, req_err, e_wait, e_err);
        else passed++;
        if (req_wait[2] === 1'b0 && dcyc < 0) begin dcyc = c; derr = req_err[2]; dload = req_load; end
        adv();
        if (dcyc >= 0) ren = '0;
      end
      checks++; if (dcyc != 8) $display("FAIL to_cycle_of_drop p%0d: got %0d expected 8", pass, dcyc); else passed++;
      checks++; if (derr !== (pass == 0 ? 1'b1 : 1'b0))
        $display("FAIL to_err p%0d: got %b expected %0d", pass, derr, pass == 0); else passed++;
      checks++; if (dload !== xload) $display("FAIL to_load p%0d: got %h expected %h", pass, dload, xload); else passed++;
    end
  endtask

  task automatic test_abort();
    apply_reset();
    addr = {32'h300, 32'h200, 32'h100}; ren = 3'b001; ram_state = 2'b10;
    tick(); adv();
    tick(); adv();
    ren = '0; wen = 3'b100; ram_state = 2'b01;
    tick(); adv();
    tick();
    checks++; if (ram_wen !== 1'b1 || ram_addr !== 32'h300)
      $display("FAIL abort_active: got wen=%b addr=%h expected 1/00000300", ram_wen, ram_addr); else passed++;
    adv();
    tick(); adv();
    wen = '0;
    tick();
    checks++; if (req_wait !== 3'b111 || ram_wen !== 1'b0 || ram_ren !== 1'b0)
      $display("FAIL abort_cycle: got wait=%b wen=%b ren=%b expected 111/0/0", req_wait, ram_wen, ram_ren); else passed++;
    adv();
    ren = 3'b101;
    tick();
    checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0)
      $display("FAIL abort_idle: got ren=%b wen=%b expected 0/0", ram_ren, ram_wen); else passed++;
    adv();
    tick();
    checks++; if (ram_addr !== 32'h300 || ram_ren !== 1'b1)
      $display("FAIL abort_ptr_kept: got addr=%h ren=%b expected 00000300/1", ram_addr, ram_ren); else passed++;
    adv();
`ifdef MEM_ARB_PERF_EN
    checks++; if (grant_cnt[47:32] !== 16'd0 || grant_cnt[15:0] !== 16'd1)
      $display("FAIL abort_cnt: got c2=%h c0=%h expected 0000/0001", grant_cnt[47:32], grant_cnt[15:0]); else passed++;
`endif
    ren = '0;
  endtask

  task automatic test_random();
    bit pend[NREQ];
    int bad;
    apply_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            int kind;
            kind = $urandom_range(0, 2);
            pend[i] = 1;
            ren[i] = (kind != 1);
            wen[i] = (kind != 0);
            addr[i*AW +: AW] = $urandom;
            store[i*DW +: DW] = $urandom;
          end else begin
            ren[i] = 0; wen[i] = 0;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          pend[i] = 0; ren[i] = 0; wen[i] = 0;
        end
      end
      begin
        int r;
        r = $urandom_range(0, 9);
        ram_state = (r <= 5) ? 2'b01 : (r <= 7) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
      end
      ram_load = $urandom;
      tick();
      checks++;
      if ({req_wait, req_err, req_load, ram_ren, ram_wen, ram_addr, ram_store} !==
          {e_wait, e_err, e_load, e_ren, e_wen, e_addr, e_store}) begin
        if (bad < 10)
          $display("FAIL rand c%0d: got wait=%b err=%b load=%h ren=%b wen=%b addr=%h st=%h expected %b/%b/%h/%b/%b/%h/%h",
                   c, req_wait, req_err, req_load, ram_ren, ram_wen, ram_addr, ram_store,
                   e_wait, e_err, e_load, e_ren, e_wen, e_addr, e_store);
        bad++;
      end else passed++;
      for (int i = 0; i < NREQ; i++) if (e_wait[i] == 1'b0) pend[i] = 0;
      adv();
      for (int i = 0; i < NREQ; i++) if (!pend[i]) begin ren[i] = 0; wen[i] = 0; end
    end
`ifdef MEM_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) begin
      checks++; if (grant_cnt[i*16 +: 16] !== 16'(m_cnt[i]))
        $display("FAIL rand_cnt %0d: got %h expected %h", i, grant_cnt[i*16 +: 16], 16'(m_cnt[i])); else passed++;
    end
`endif
    ren = '0; wen = '0;
  endtask

  initial begin
    rst = 1; ren = '0; wen = '0; addr = '0; store = '0; ram_state = 2'b00; ram_load = '0;
    model_reset();
    test_reset();
    test_single_read();
    test_fairness();
    test_write_priority();
    test_timeout();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
